mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 64, address width.
- DATA_W, default 64, data width; multiple of 8, >= 8.
- RR, default 1: 1 = round-robin between channels; 0 = fixed priority, data channel wins.
- SEL_W SHALL equal DATA_W/8.
REQ-002 One clock; reset is synchronous and active-high. Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req_valid  in  1  instruction-fetch read request
- i_req_ready  out  1  instruction request accepted this cycle
- i_req_addr  in  ADDR_W  fetch address
- i_resp_valid  out  1  fetch data valid, one-cycle pulse
- i_resp_data  out  DATA_W  fetch data
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_we  in  1  1 = write, 0 = read
- d_req_addr  in  ADDR_W  data address
- d_req_wdata  in  DATA_W  write data
- d_req_sel  in  SEL_W  byte-enable mask
- d_resp_valid  out  1  data read or write completion, one-cycle pulse
- d_resp_data  out  DATA_W  read data
- m_req_valid  out  1  downstream request valid
- m_req_ready  in  1  downstream accepts request
- m_req_we, m_req_addr, m_req_wdata, m_req_sel  out  1/ADDR_W/DATA_W/SEL_W  downstream request fields
- m_resp_valid  in  1  downstream response valid
- m_resp_data  in  DATA_W  downstream response data
- busy  out  1  transaction in flight

Function
REQ-003 The block SHALL hold at most one outstanding transaction, using FSM states IDLE, ISSUE, WAIT, DONE.
REQ-004 IDLE: with no valid request, the block SHALL stay in IDLE.
REQ-005 IDLE with any valid request: the block SHALL choose a winner, pulse that channel's req_ready for exactly this cycle, latch owner and request fields, and go to ISSUE.
REQ-006 The losing channel's req_ready SHALL stay 0; its request stays pending and the requester holds it.
REQ-007 RR=0: when both channels are valid, data SHALL win.
REQ-008 RR=1: when both channels are valid, the channel not granted last SHALL win.
- The last_grant register SHALL update on every grant.
- last_grant SHALL reset to instruction, so the first contested grant goes to data.
REQ-009 Instruction-channel grants SHALL latch we=0, wdata=0 and sel=all ones.
REQ-010 ISSUE: m_req_valid=1 with latched fields held stable.
- On m_req_ready=1 the block SHALL go to WAIT.
- Otherwise it SHALL stay in ISSUE with fields unchanged.
REQ-011 WAIT: on m_resp_valid=1 the block SHALL latch m_resp_data and go to DONE.
REQ-012 m_resp_valid SHALL be ignored in IDLE, ISSUE and DONE.
REQ-013 DONE: the owner's resp_valid SHALL be 1 for exactly one cycle with the latched data; the next state is IDLE.
REQ-014 In DONE, the non-owner resp_valid SHALL be 0; both resp_data outputs SHALL carry the latched data.
REQ-015 Writes SHALL complete exactly like reads: d_resp_valid pulses in DONE, and d_resp_data is the latched m_resp_data, unspecified content.
REQ-016 Minimum latency: accept at cycle N, m_req_valid at N+1; if ready at N+1 and response at N+2, owner resp_valid at N+3.
REQ-017 A new request SHALL be acceptable no earlier than the cycle after DONE; back-to-back throughput is one transaction per 4 cycles minimum.
REQ-018 busy SHALL be 1 exactly when the state is not IDLE.
REQ-019 Request inputs SHALL be ignored outside IDLE; req_ready SHALL be 0 outside IDLE.
REQ-020 The block SHALL perform no address alignment or byte-lane shifting; fields pass through unchanged.

Reset
REQ-021 With rst=1 at a clock edge: state=IDLE, last_grant=instruction, latched fields=0.
REQ-022 All outputs SHALL be 0 in the cycle after rst is sampled high, and for as long as rst stays high.
REQ-023 Reset in ISSUE, WAIT or DONE SHALL abandon the transaction.
- No resp_valid SHALL be delivered for it.
- A later stray m_resp_valid SHALL be ignored, per REQ-012.

Verification
REQ-024 Single fetch: i_req_valid=1, addr=0x80000000; memory ready immediately, response 0x00000013 one cycle later.
- Expected: i_req_ready at N, m_req_addr=0x80000000 with sel=0xFF at N+1, i_resp_valid with data 0x13 at N+3.
REQ-025 Contention, RR=1: both channels held valid for 3 grants.
- Expected grant order D, I, D.
- With RR=0 the data channel SHALL win all three grants.
REQ-026 Write: d_req we=1, addr=0x80001000, wdata=0xDEADBEEF, sel=0x0F; m_req_ready held 0 for 5 cycles.
- Expected: m_req fields stable for all 6 ISSUE cycles, then one d_resp_valid pulse.
REQ-027 Stray response: m_resp_valid=1 in IDLE and in ISSUE.
- Expected: no resp_valid pulse and no state change from it.
REQ-028 Reset in WAIT: rst pulsed 1 cycle, then m_resp_valid=1 with 0x1234.
- Expected: all outputs 0, no resp_valid ever, busy=0; the next request is served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Arbitrates an instruction-fetch read port and a data read/write port onto
// a single downstream memory port. Only one transaction is in flight at a time:
// IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   i_req_* / i_resp_*           instruction fetch request/response (read only)
//   d_req_* / d_resp_*           data request/response (read or write)
//   m_req_* / m_resp_*           downstream memory request/response
//   busy                         high whenever a transaction is in flight
//
// Parameters
//   ADDR_W  address width
//   DATA_W  data width (multiple of 8)
//   RR      1 = round-robin on contention, 0 = data channel always wins
//   SEL_W   byte-enable width, derived as DATA_W/8
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int RR     = 1,
  localparam int SEL_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic [SEL_W-1:0]  d_req_sel,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic              m_req_we,
  output logic [ADDR_W-1:0] m_req_addr,
  output logic [DATA_W-1:0] m_req_wdata,
  output logic [SEL_W-1:0]  m_req_sel,
  input  logic              m_resp_valid,
  input  logic [DATA_W-1:0] m_resp_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Channel encoding for owner/last_grant: 0 = instruction, 1 = data.
  logic              owner_reg;
  logic              last_grant_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic grant_i;
  logic grant_d;

  // Next-state and grant selection. Grants are suppressed while rst is high
  // so that no ready pulse escapes during reset.
  always_comb begin
    state_next = state_reg;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rst) begin
          if (i_req_valid && d_req_valid) begin
            // Round-robin: whoever was not granted last wins the tie.
            if ((RR != 0) && last_grant_reg) grant_i = 1'b1;
            else                             grant_d = 1'b1;
          end else if (d_req_valid) begin
            grant_d = 1'b1;
          end else if (i_req_valid) begin
            grant_i = 1'b1;
          end
        end
        if (grant_i || grant_d) state_next = ISSUE;
      end
      ISSUE: if (m_req_ready)  state_next = WAIT;
      WAIT:  if (m_resp_valid) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      sel_reg        <= '0;
      rdata_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_i || grant_d) begin
        owner_reg      <= grant_d;
        last_grant_reg <= grant_d;
        // Fetches are always full-width reads.
        we_reg    <= grant_d ? d_req_we    : 1'b0;
        addr_reg  <= grant_d ? d_req_addr  : i_req_addr;
        wdata_reg <= grant_d ? d_req_wdata : '0;
        sel_reg   <= grant_d ? d_req_sel   : '1;
      end
      // Responses are only meaningful while waiting; strays elsewhere drop.
      if (state_reg == WAIT && m_resp_valid) rdata_reg <= m_resp_data;
    end
  end

  assign i_req_ready  = grant_i;
  assign d_req_ready  = grant_d;

  assign m_req_valid  = (state_reg == ISSUE);
  assign m_req_we     = we_reg;
  assign m_req_addr   = addr_reg;
  assign m_req_wdata  = wdata_reg;
  assign m_req_sel    = sel_reg;

  assign i_resp_valid = (state_reg == DONE) && !owner_reg;
  assign d_resp_valid = (state_reg == DONE) &&  owner_reg;
  assign i_resp_data  = rdata_reg;
  assign d_resp_data  = rdata_reg;

  assign busy         = (state_reg != IDLE);

endmodule
